// File: rtl/zero_detect_pipe.sv
// Pipelined zero/ones/masked/equality detector: a per-bit "ok" vector is AND-reduced
// over LEVELS registered tree levels of fan-in GROUP, with valid/ready flow control.
module zero_detect_pipe #(
    parameter int WIDTH = 64,
    parameter int GROUP = 4,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] in_cmp,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_flag,
    output logic [TAG_W-1:0] out_tag,
    output logic             sticky_flag,
    input  logic             sticky_clr
);

    function automatic int calc_levels(input int w, input int g);
        int lv;
        int span;
        lv   = 1;
        span = g;
        while (span < w) begin
            span = span * g;
            lv++;
        end
        return lv;
    endfunction

    function automatic int calc_span(input int g, input int lv);
        int span;
        span = 1;
        for (int i = 0; i < lv; i++) begin
            span = span * g;
        end
        return span;
    endfunction

    localparam int LEVELS = calc_levels(WIDTH, GROUP);
    localparam int PW     = calc_span(GROUP, LEVELS);

    logic             adv;
    logic [WIDTH-1:0] bit_ok;
    logic [PW-1:0]    ok_pad;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    always_comb begin
        case (in_mode)
            2'b00:   bit_ok = ~in_data;
            2'b01:   bit_ok = in_data;
            2'b10:   bit_ok = ~(in_data & in_cmp);
            default: bit_ok = ~(in_data ^ in_cmp);
        endcase
    end

    // Pad positions are forced to 1 so they can never pull the AND tree low.
    always_comb begin
        ok_pad = '1;
        for (int i = 0; i < WIDTH; i++) begin
            ok_pad[i] = bit_ok[i];
        end
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_level
        logic [PW-1:0]    src;
        logic             src_valid;
        logic [TAG_W-1:0] src_tag;
        logic [PW-1:0]    reduced;
        logic [PW-1:0]    data_q;
        logic             valid_q;
        logic [TAG_W-1:0] tag_q;

        if (l == 0) begin : g_first
            assign src       = ok_pad;
            assign src_valid = in_valid;
            assign src_tag   = in_tag;
        end else begin : g_next
            assign src       = g_level[l-1].data_q;
            assign src_valid = g_level[l-1].valid_q;
            assign src_tag   = g_level[l-1].tag_q;
        end

        // Node j ANDs source bits j*GROUP .. j*GROUP+GROUP-1; nodes past the live range stay 1.
        always_comb begin
            reduced = '1;
            for (int i = 0; i < PW; i++) begin
                reduced[i/GROUP] = reduced[i/GROUP] & src[i];
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                tag_q   <= '0;
            end else if (adv) begin
                valid_q <= src_valid;
                data_q  <= reduced;
                tag_q   <= src_tag;
            end
        end
    end

    assign out_valid = g_level[LEVELS-1].valid_q;
    assign out_flag  = &g_level[LEVELS-1].data_q;
    assign out_tag   = g_level[LEVELS-1].tag_q;

    // A setting handshake takes priority over a coincident clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_flag <= 1'b0;
        end else if (out_valid && out_ready && out_flag) begin
            sticky_flag <= 1'b1;
        end else if (sticky_clr) begin
            sticky_flag <= 1'b0;
        end
    end

endmodule

// File: doc/zero_detect_pipe.md
ZERO_DETECT_PIPE -- requirements
Module: zero_detect_pipe

Interface
REQ-001 Parameter WIDTH, default 64: data width in bits, legal range 2..256.
REQ-002 Parameter GROUP, default 4: fan-in of each reduction node, legal range 2..8.
REQ-003 Parameter TAG_W, default 5: width of the sideband tag; the tag passes through unchanged.
REQ-004 Derived constant LEVELS = ceil(log_GROUP(WIDTH)); for the defaults LEVELS = 3.
REQ-005 Port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-006 Port reset, input, 1: synchronous active-high reset, sampled on the rising edge of clk.
REQ-007 Port in_valid, input, 1: the input beat is valid.
REQ-008 Port in_ready, output, 1: the block accepts the beat this cycle.
REQ-009 Port in_data, input, WIDTH: operand.
REQ-010 Port in_cmp, input, WIDTH: operand B, used for masked and equality modes.
REQ-011 Port in_mode, input, 2: 00 all-zero; 01 all-ones; 10 masked-zero, (data AND cmp)==0; 11 equality, data==cmp.
REQ-012 Port in_tag, input, TAG_W: sideband tag.
REQ-013 Port out_valid, output, 1: a result is presented.
REQ-014 Port out_ready, input, 1: the consumer accepts the result.
REQ-015 Port out_flag, output, 1: 1 when the selected condition holds for the beat.
REQ-016 Port out_tag, output, TAG_W: the tag of the presented result.
REQ-017 Port sticky_flag, output, 1: OR of all accepted out_flag values since the last clear.
REQ-018 Port sticky_clr, input, 1: clears sticky_flag.

Function
REQ-019 Each beat shall be pre-reduced per bit to a "bit ok" vector:
- mode 00: NOT d
- mode 01: d
- mode 10: NOT (d AND c)
- mode 11: NOT (d XOR c)
REQ-020 The "bit ok" vector shall be reduced by AND over LEVELS pipeline levels, each level combining GROUP signals from the level before.
REQ-021 Each level's results, valid bit and tag shall be registered.
REQ-022 When WIDTH is not a multiple of GROUP^LEVELS, pad bits shall be treated as "ok" (1), so they never affect out_flag.
REQ-023 Latency from an accepted input (in_valid & in_ready) to the corresponding out_valid shall be exactly LEVELS cycles when there is no stall.
REQ-024 The pipeline shall advance when adv = !out_valid | out_ready.
REQ-025 in_ready shall equal adv.
REQ-026 When adv = 0, all stage registers shall hold their values.
REQ-027 When a stage advances, it shall take the valid bit from its predecessor, including bubbles (valid = 0).
REQ-028 Throughput shall be one beat per cycle while out_ready is held at 1.
REQ-029 While out_valid = 1 and out_ready = 0, out_flag and out_tag shall remain stable.
REQ-030 Results shall leave in input order, and each accepted beat shall produce exactly one result.
REQ-031 sticky_flag shall be set on a cycle when out_valid & out_ready & out_flag.
REQ-032 When sticky_clr coincides with a setting handshake, the set shall win (sticky_flag = 1 next cycle).
REQ-033 When sticky_clr occurs without a setting handshake, sticky_flag shall be 0 next cycle.
REQ-034 in_mode and in_cmp shall be sampled with in_data only, so a mode change between beats affects only later beats.
REQ-035 For GROUP >= WIDTH, LEVELS = 1 and latency shall be 1.

Reset
REQ-036 While reset = 1, all stage valid bits, out_valid and sticky_flag shall be 0 at the next edge.
REQ-037 While reset = 1, out_flag shall be 0 and out_tag shall be 0.
REQ-038 While reset = 1, in_ready shall be 1, since adv = 1 when out_valid = 0.
REQ-039 A beat presented during reset shall be discarded.
REQ-040 A reset asserted mid-operation shall flush all in-flight beats, and no result for them shall appear after reset is released.
REQ-041 The first beat accepted after reset shall emerge LEVELS cycles later.

Verification
REQ-042 Defaults, out_ready = 1, back-to-back beats:
- mode 00, data 0x0 -> flag 1, at cycle +3
- mode 00, data 0x8000_0000_0000_0000 -> flag 0, at cycle +4
REQ-043 Mode 01 with data 0xFFFF_FFFF_FFFF_FFFF -> flag 1; mode 01 with 0xFFFF_FFFF_FFFF_FFFE -> flag 0.
REQ-044 Mode 10 with data 0xF0, cmp 0x0F -> flag 1; mode 11 with data = cmp = 0x1234 -> flag 1; mode 11 with data 0x1234, cmp 0x1235 -> flag 0.
REQ-045 Stall test:
- stimulus: 5 beats with tags 1..5, out_ready low for 4 cycles after the first result
- response: in_ready low during the stall; output held at tag 1; tags then leave 1..5 in order with no loss or duplication
REQ-046 Sticky test:
- sticky_clr coincident with a flag=1 handshake -> sticky_flag = 1
- sticky_clr alone -> 0 next cycle
REQ-047 Parameter and reset test:
- WIDTH = 10, GROUP = 4 (LEVELS = 2), data 0x000 -> flag 1 at latency 2; data 0x200 -> flag 0
- reset pulsed with 2 beats in flight -> out_valid stays 0 after reset
